// File: rtl/i2c_target_pkg.sv
// Shared types and constants for the I2C register target: FSM state encoding,
// bus ACK/NACK levels and the glitch-filter length.
package i2c_target_pkg;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_ADDR,
    ST_ADDR_ACK,
    ST_PTR,
    ST_PTR_ACK,
    ST_WDATA,
    ST_WDATA_ACK,
    ST_RDATA,
    ST_RDATA_ACK
  } state_t;

  localparam logic I2C_ACK  = 1'b0;
  localparam logic I2C_NACK = 1'b1;
  localparam int   FILT_LEN = 3;

  function automatic logic majority3(input logic [2:0] s);
    return (s[0] & s[1]) | (s[0] & s[2]) | (s[1] & s[2]);
  endfunction

endpackage

// File: rtl/i2c_line_filter.sv
// Synchronizes and majority-filters SCL and SDA, then derives SCL edges and
// START/STOP conditions from the filtered pair.
module i2c_line_filter
  import i2c_target_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic scl_i,
  input  logic sda_i,
  output logic sda,
  output logic scl_rise,
  output logic scl_fall,
  output logic start_det,
  output logic stop_det
);

  logic [1:0]          scl_sync_q, scl_sync_d, sda_sync_q, sda_sync_d;
  logic [FILT_LEN-1:0] scl_hist_q, scl_hist_d, sda_hist_q, sda_hist_d;
  logic                scl_f_q, scl_f_d, scl_p_q, scl_p_d;
  logic                sda_f_q, sda_f_d, sda_p_q, sda_p_d;

  always_comb begin
    scl_sync_d = {scl_sync_q[0], scl_i};
    sda_sync_d = {sda_sync_q[0], sda_i};
    scl_hist_d = {scl_hist_q[FILT_LEN-2:0], scl_sync_q[1]};
    sda_hist_d = {sda_hist_q[FILT_LEN-2:0], sda_sync_q[1]};
    scl_f_d    = majority3(scl_hist_q);
    sda_f_d    = majority3(sda_hist_q);
    scl_p_d    = scl_f_q;
    sda_p_d    = sda_f_q;
  end

  // Idle bus is high on both lines, so everything resets to 1.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      scl_sync_q <= '1;
      sda_sync_q <= '1;
      scl_hist_q <= '1;
      sda_hist_q <= '1;
      scl_f_q    <= 1'b1;
      sda_f_q    <= 1'b1;
      scl_p_q    <= 1'b1;
      sda_p_q    <= 1'b1;
    end else begin
      scl_sync_q <= scl_sync_d;
      sda_sync_q <= sda_sync_d;
      scl_hist_q <= scl_hist_d;
      sda_hist_q <= sda_hist_d;
      scl_f_q    <= scl_f_d;
      sda_f_q    <= sda_f_d;
      scl_p_q    <= scl_p_d;
      sda_p_q    <= sda_p_d;
    end
  end

  assign sda       = sda_f_q;
  assign scl_rise  = scl_f_q & ~scl_p_q;
  assign scl_fall  = ~scl_f_q & scl_p_q;
  assign start_det = scl_f_q & scl_p_q & sda_p_q & ~sda_f_q;
  assign stop_det  = scl_f_q & scl_p_q & ~sda_p_q & sda_f_q;

endmodule

// File: rtl/i2c_target_core.sv
// I2C register-file target: write sets a pointer then auto-increments data writes,
// read streams mem[ptr] onward. Define I2C_GEN_CALL_EN to accept general-call writes.
module i2c_target_core
  import i2c_target_pkg::*;
#(
  parameter logic [6:0] SLAVE_ADDR = 7'h3A,
  parameter int         MEM_DEPTH  = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       scl_i,
  input  logic       sda_i,
  output logic       sda_oe,
  output logic       wr_valid,
  output logic [7:0] wr_addr,
  output logic [7:0] saved_data,
  output logic       busy,
  output state_t     dbg_state
);

  localparam int PW = $clog2(MEM_DEPTH);

  logic sda, scl_rise, scl_fall, start_det, stop_det;

  i2c_line_filter u_filter (
    .clk(clk), .rst(rst), .scl_i(scl_i), .sda_i(sda_i),
    .sda(sda), .scl_rise(scl_rise), .scl_fall(scl_fall),
    .start_det(start_det), .stop_det(stop_det)
  );

  state_t          state_q, state_d;
  logic [3:0]      bit_cnt_q, bit_cnt_d;
  logic [7:0]      shift_q, shift_d;
  logic [PW-1:0]   ptr_q, ptr_d, ptr_inc;
  logic            rw_q, rw_d, busy_q, busy_d;
  logic            sda_oe_q, sda_oe_d, wr_valid_q, wr_valid_d;
  logic [7:0]      wr_addr_q, wr_addr_d, saved_data_q, saved_data_d;
  logic [7:0]      mem_q [MEM_DEPTH];
  logic            mem_we, addr_hit, gen_hit;

  assign ptr_inc = ptr_q + PW'(1);

`ifdef I2C_GEN_CALL_EN
  assign gen_hit = (shift_q == 8'h00);
`else
  assign gen_hit = 1'b0;
`endif
  assign addr_hit = (shift_q[7:1] == SLAVE_ADDR) || gen_hit;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      bit_cnt_q    <= '0;
      shift_q      <= '0;
      ptr_q        <= '0;
      rw_q         <= 1'b0;
      busy_q       <= 1'b0;
      sda_oe_q     <= 1'b0;
      wr_valid_q   <= 1'b0;
      wr_addr_q    <= '0;
      saved_data_q <= '0;
      for (int i = 0; i < MEM_DEPTH; i++) mem_q[i] <= '0;
    end else begin
      state_q      <= state_d;
      bit_cnt_q    <= bit_cnt_d;
      shift_q      <= shift_d;
      ptr_q        <= ptr_d;
      rw_q         <= rw_d;
      busy_q       <= busy_d;
      sda_oe_q     <= sda_oe_d;
      wr_valid_q   <= wr_valid_d;
      wr_addr_q    <= wr_addr_d;
      saved_data_q <= saved_data_d;
      if (mem_we) mem_q[ptr_q] <= shift_q;
    end
  end

  // Bits are taken on SCL rise; every state change and SDA update happens on SCL fall,
  // except START/STOP which can only move the FSM to states that release SDA.
  always_comb begin
    state_d   = state_q;
    bit_cnt_d = bit_cnt_q;
    shift_d   = shift_q;
    ptr_d     = ptr_q;
    rw_d      = rw_q;
    busy_d    = busy_q;
    mem_we    = 1'b0;
    if (start_det) begin
      state_d   = ST_ADDR;
      bit_cnt_d = '0;
    end else if (stop_det) begin
      state_d = ST_IDLE;
      busy_d  = 1'b0;
    end else if (scl_rise) begin
      if (state_q inside {ST_ADDR, ST_PTR, ST_WDATA, ST_RDATA_ACK})
        shift_d = {shift_q[6:0], sda};
      if (state_q != ST_IDLE) bit_cnt_d = bit_cnt_q + 4'd1;
    end else if (scl_fall) begin
      case (state_q)
        ST_ADDR: if (bit_cnt_q == 4'd8) begin
          bit_cnt_d = '0;
          if (addr_hit && !(gen_hit && shift_q[0])) begin
            state_d = ST_ADDR_ACK;
            rw_d    = shift_q[0];
            busy_d  = 1'b1;
          end else begin
            state_d = ST_IDLE;
            busy_d  = 1'b0;
          end
        end
        ST_ADDR_ACK: begin
          bit_cnt_d = '0;
          if (rw_q) begin
            state_d = ST_RDATA;
            shift_d = mem_q[ptr_q];
          end else begin
            state_d = ST_PTR;
          end
        end
        ST_PTR: if (bit_cnt_q == 4'd8) begin
          state_d   = ST_PTR_ACK;
          ptr_d     = shift_q[PW-1:0];
          bit_cnt_d = '0;
        end
        ST_PTR_ACK, ST_WDATA_ACK: begin
          state_d   = ST_WDATA;
          bit_cnt_d = '0;
        end
        ST_WDATA: if (bit_cnt_q == 4'd8) begin
          state_d   = ST_WDATA_ACK;
          mem_we    = 1'b1;
          ptr_d     = ptr_inc;
          bit_cnt_d = '0;
        end
        ST_RDATA: begin
          if (bit_cnt_q == 4'd8) begin
            state_d   = ST_RDATA_ACK;
            bit_cnt_d = '0;
          end else begin
            shift_d = {shift_q[6:0], 1'b0};
          end
        end
        ST_RDATA_ACK: begin
          bit_cnt_d = '0;
          if (shift_q[0] == I2C_NACK) begin
            state_d = ST_IDLE;
            busy_d  = 1'b0;
          end else begin
            state_d = ST_RDATA;
            ptr_d   = ptr_inc;
            shift_d = mem_q[ptr_inc];
          end
        end
        default: ;
      endcase
    end
  end

  // SDA drive is decoded from the next state so it registers on the same clock as the move.
  always_comb begin
    sda_oe_d = 1'b0;
    case (state_d)
      ST_ADDR_ACK, ST_PTR_ACK, ST_WDATA_ACK: sda_oe_d = ~I2C_ACK;
      ST_RDATA:                              sda_oe_d = ~shift_d[7];
      default:                               sda_oe_d = 1'b0;
    endcase
    wr_valid_d   = mem_we;
    wr_addr_d    = mem_we ? 8'(ptr_q) : wr_addr_q;
    saved_data_d = mem_we ? shift_q : saved_data_q;
  end

  assign sda_oe     = sda_oe_q;
  assign wr_valid   = wr_valid_q;
  assign wr_addr    = wr_addr_q;
  assign saved_data = saved_data_q;
  assign busy       = busy_q;
  assign dbg_state  = state_q;

endmodule

// File: tb/tb_i2c_target_core.sv
// Directed bench for i2c_target_core: a bit-level I2C master drives the bus and
// every observation is checked against hand-computed values.
module tb_i2c_target_core;
  import i2c_target_pkg::*;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       scl_m = 1'b1;
  logic       sda_m = 1'b1;
  logic       sda_oe, wr_valid, busy;
  logic [7:0] wr_addr, saved_data;
  state_t     dbg_state;
  wire        sda_line = sda_m & ~sda_oe;

  always #5 clk = ~clk;

  i2c_target_core #(.SLAVE_ADDR(7'h3A), .MEM_DEPTH(8)) dut (
    .clk(clk), .rst(rst), .scl_i(scl_m), .sda_i(sda_line),
    .sda_oe(sda_oe), .wr_valid(wr_valid), .wr_addr(wr_addr),
    .saved_data(saved_data), .busy(busy), .dbg_state(dbg_state)
  );

  int n_cmp = 0;
  int n_err = 0;
  int wr_cnt = 0;
  int wr_idx = 0;
  int oe_cycles = 0;
  int oe_viol = 0;
  logic [7:0] wr_a_log [64];
  logic [7:0] wr_d_log [64];
  logic oe_prev = 1'b0;
  logic scl_prev = 1'b1;

  // Bus monitor: logs committed writes, counts SDA drive cycles and
  // any pull-down that starts while SCL is already high.
  always @(posedge clk) begin
    if (wr_valid && wr_cnt < 64) begin
      wr_a_log[wr_cnt] <= wr_addr;
      wr_d_log[wr_cnt] <= saved_data;
      wr_cnt <= wr_cnt + 1;
    end
    if (sda_oe) oe_cycles <= oe_cycles + 1;
    if (sda_oe && !oe_prev && scl_m && scl_prev) oe_viol <= oe_viol + 1;
    oe_prev  <= sda_oe;
    scl_prev <= scl_m;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_wr(input string tag, input logic [7:0] a, input logic [7:0] d);
    check({tag, "_addr"}, 32'(wr_a_log[wr_idx]), 32'(a));
    check({tag, "_data"}, 32'(wr_d_log[wr_idx]), 32'(d));
    wr_idx++;
  endtask

  task automatic q_wait;
    repeat (10) @(posedge clk);
    #1;
  endtask

  task automatic bus_start;
    sda_m = 1'b1; q_wait;
    scl_m = 1'b1; q_wait;
    sda_m = 1'b0; q_wait;
    scl_m = 1'b0; q_wait;
  endtask

  task automatic bus_stop;
    sda_m = 1'b0; q_wait;
    scl_m = 1'b1; q_wait;
    sda_m = 1'b1; q_wait;
  endtask

  task automatic bus_bit(input logic b, output logic r);
    sda_m = b;    q_wait;
    scl_m = 1'b1; q_wait;
    r = sda_line; q_wait;
    scl_m = 1'b0; q_wait;
  endtask

  task automatic wr_byte(input logic [7:0] d, output logic ack);
    logic r;
    for (int i = 7; i >= 0; i--) bus_bit(d[i], r);
    bus_bit(1'b1, ack);
  endtask

  task automatic rd_byte(input logic m_ack, output logic [7:0] d);
    logic r;
    for (int i = 7; i >= 0; i--) begin
      bus_bit(1'b1, r);
      d[i] = r;
    end
    bus_bit(m_ack, r);
  endtask

  initial begin
    logic       ack;
    logic       r;
    logic [7:0] d;
    int         oe_snap;

    // Reset state
    repeat (5) @(posedge clk);
    #1;
    check("rst_sda_oe", 32'(sda_oe), 32'd0);
    check("rst_wr_valid", 32'(wr_valid), 32'd0);
    check("rst_wr_addr", 32'(wr_addr), 32'h00);
    check("rst_saved", 32'(saved_data), 32'h00);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_state", 32'(dbg_state), 32'(ST_IDLE));
    rst = 1'b0;
    q_wait;

    // Pointer write then two data writes
    bus_start;
    wr_byte(8'h74, ack); check("w1_addr_ack", 32'(ack), 32'd0);
    check("w1_busy", 32'(busy), 32'd1);
    wr_byte(8'h02, ack); check("w1_ptr_ack", 32'(ack), 32'd0);
    wr_byte(8'hA5, ack); check("w1_d0_ack", 32'(ack), 32'd0);
    wr_byte(8'h5C, ack); check("w1_d1_ack", 32'(ack), 32'd0);
    bus_stop;
    q_wait;
    check("w1_count", 32'(wr_cnt), 32'd2);
    check_wr("w1_0", 8'h02, 8'hA5);
    check_wr("w1_1", 8'h03, 8'h5C);
    check("w1_saved_hold", 32'(saved_data), 32'h5C);
    check("w1_busy_end", 32'(busy), 32'd0);
    check("w1_state_end", 32'(dbg_state), 32'(ST_IDLE));

    // Fill mem[7] and mem[0] across the pointer wrap
    bus_start;
    wr_byte(8'h74, ack);
    wr_byte(8'h07, ack);
    wr_byte(8'h3C, ack); check("w2_d0_ack", 32'(ack), 32'd0);
    wr_byte(8'hC3, ack); check("w2_d1_ack", 32'(ack), 32'd0);
    bus_stop;
    q_wait;
    check("w2_count", 32'(wr_cnt), 32'd4);
    check_wr("w2_0", 8'h07, 8'h3C);
    check_wr("w2_1", 8'h00, 8'hC3);

    // Set ptr 7, repeated START, read two bytes with wrap
    bus_start;
    wr_byte(8'h74, ack);
    wr_byte(8'h07, ack);
    bus_start;
    wr_byte(8'h75, ack); check("r1_addr_ack", 32'(ack), 32'd0);
    rd_byte(1'b0, d);    check("r1_mem7", 32'(d), 32'h3C);
    rd_byte(1'b1, d);    check("r1_mem0", 32'(d), 32'hC3);
    check("r1_sda_rel", 32'(sda_oe), 32'd0);
    check("r1_state", 32'(dbg_state), 32'(ST_IDLE));
    bus_stop;
    q_wait;

    // Foreign address is ignored
    oe_snap = oe_cycles;
    bus_start;
    wr_byte(8'h90, ack); check("na_nack", 32'(ack), 32'd1);
    check("na_busy", 32'(busy), 32'd0);
    wr_byte(8'h00, ack); check("na_data_nack", 32'(ack), 32'd1);
    check("na_no_oe", 32'(oe_cycles - oe_snap), 32'd0);
    bus_stop;
    q_wait;

    // STOP in the middle of a data byte discards it
    bus_start;
    wr_byte(8'h74, ack);
    wr_byte(8'h05, ack);
    for (int i = 0; i < 4; i++) bus_bit(1'b1, r);
    bus_stop;
    q_wait;
    check("part_count", 32'(wr_cnt), 32'd4);
    check("part_state", 32'(dbg_state), 32'(ST_IDLE));
    check("part_sda_oe", 32'(sda_oe), 32'd0);

    // Reset while driving a read bit low
    bus_start;
    wr_byte(8'h74, ack);
    wr_byte(8'h02, ack);
    bus_start;
    wr_byte(8'h75, ack);
    bus_bit(1'b1, r);    check("rr_bit7", 32'(r), 32'd1);
    check("rr_driving", 32'(sda_oe), 32'd1);
    check("rr_state", 32'(dbg_state), 32'(ST_RDATA));
    rst = 1'b1;
    #1;
    check("rr_async_rel", 32'(sda_oe), 32'd0);
    check("rr_busy", 32'(busy), 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    q_wait;
    bus_start;
    wr_byte(8'h74, ack); check("rr_w_addr_ack", 32'(ack), 32'd0);
    wr_byte(8'h01, ack);
    wr_byte(8'h99, ack); check("rr_w_data_ack", 32'(ack), 32'd0);
    bus_stop;
    q_wait;
    check("rr_count", 32'(wr_cnt), 32'd5);
    check_wr("rr_w", 8'h01, 8'h99);
    bus_start;
    wr_byte(8'h74, ack);
    wr_byte(8'h01, ack);
    bus_start;
    wr_byte(8'h75, ack);
    rd_byte(1'b1, d);    check("rr_readback", 32'(d), 32'h99);
    bus_stop;
    q_wait;

    // General call
    bus_start;
    wr_byte(8'h00, ack);
`ifdef I2C_GEN_CALL_EN
    check("gc_addr_ack", 32'(ack), 32'd0);
    wr_byte(8'h01, ack); check("gc_ptr_ack", 32'(ack), 32'd0);
    wr_byte(8'h11, ack); check("gc_data_ack", 32'(ack), 32'd0);
    bus_stop;
    q_wait;
    check("gc_count", 32'(wr_cnt), 32'd6);
    check_wr("gc_w", 8'h01, 8'h11);
`else
    check("gc_addr_nack", 32'(ack), 32'd1);
    wr_byte(8'h01, ack); check("gc_ptr_nack", 32'(ack), 32'd1);
    wr_byte(8'h11, ack); check("gc_data_nack", 32'(ack), 32'd1);
    bus_stop;
    q_wait;
    check("gc_count", 32'(wr_cnt), 32'd5);
`endif

    check("oe_while_scl_high", 32'(oe_viol), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
